// File: rtl/ysyx_23060025_mem_responder.sv
// Burst memory responder: arbitrates instruction reads, data reads and data
// writes onto a single word-wide synchronous RAM with a five-state FSM.
module ysyx_23060025_mem_responder #(
  parameter int LINE_W = 128,
  parameter int RAM_AW = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inst_psel,
  input  logic [31:0]       inst_paddr,
  input  logic [7:0]        inst_plen,
  input  logic [2:0]        inst_psize,
  output logic              inst_pvalid,
  output logic              inst_plast,
  output logic [31:0]       inst_prdata,
  input  logic              data_prsel,
  input  logic [31:0]       data_praddr,
  input  logic [7:0]        data_prlen,
  input  logic [2:0]        data_prsize,
  output logic              data_pvalid,
  output logic              data_prlast,
  output logic [31:0]       data_prdata,
  input  logic              data_pwsel,
  input  logic [31:0]       data_pwaddr,
  input  logic [LINE_W-1:0] data_pwdata,
  input  logic [3:0]        data_pwstrb,
  input  logic [2:0]        data_pwtype,
  output logic              data_pwrdy,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int BEATS = LINE_W / 32;
  localparam int LINE_LB = $clog2(BEATS);
  localparam logic [RAM_AW-1:0] LINE_MASK = ~RAM_AW'((1 << LINE_LB) - 1);
  localparam logic [7:0] LINE_LEN = 8'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, IRD, DRD, DWR, DONE} state_e;

  state_e              state_q, state_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [7:0]          len_q, len_d;
  logic [RAM_AW-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [3:0]          strb_q, strb_d;
  logic                vld_p1_q, vld_p1_d;
  logic                last_p1_q, last_p1_d;
  logic                issue;
  logic                line_wr;
  logic [RAM_AW-1:0]   pw_idx;

  // Size hints and the address bits above the RAM are deliberately ignored.
  logic unused_inputs;
  assign unused_inputs = ^{inst_psize, data_prsize, inst_paddr[31:RAM_AW+2], inst_paddr[1:0],
                           data_praddr[31:RAM_AW+2], data_praddr[1:0],
                           data_pwaddr[31:RAM_AW+2], data_pwaddr[1:0]};

  assign line_wr = (data_pwtype == 3'b001);
  assign pw_idx  = data_pwaddr[RAM_AW+1:2];
  assign issue   = ((state_q == IRD) || (state_q == DRD) || (state_q == DWR)) &&
                   (cnt_q <= {1'b0, len_q});

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vld_p1_q  <= vld_p1_d;
      last_p1_q <= last_p1_d;
    end
  end

  always_ff @(posedge clock) begin
    len_q  <= len_d;
    addr_q <= addr_d;
    line_q <= line_d;
    strb_q <= strb_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    addr_d    = addr_q;
    line_d    = line_q;
    strb_d    = strb_q;
    vld_p1_d  = 1'b0;
    last_p1_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (data_pwsel) begin
          state_d = DWR;
          line_d  = data_pwdata;
          if (line_wr) begin
            addr_d = pw_idx & LINE_MASK;
            len_d  = LINE_LEN;
            strb_d = 4'hF;
          end else begin
            addr_d = pw_idx;
            len_d  = '0;
            strb_d = data_pwstrb;
          end
        end else if (data_prsel) begin
          state_d = DRD;
          addr_d  = data_praddr[RAM_AW+1:2];
          len_d   = data_prlen;
        end else if (inst_psel) begin
          state_d = IRD;
          addr_d  = inst_paddr[RAM_AW+1:2];
          len_d   = inst_plen;
        end
      end
      // p0: RAM read issued; p1: RAM data returns one cycle later
      IRD, DRD: begin
        if (issue) cnt_d = cnt_q + 9'd1;
        vld_p1_d  = issue;
        last_p1_d = issue && (cnt_q[7:0] == len_q);
        if (last_p1_q) state_d = DONE;
      end
      DWR: begin
        if (issue) begin
          cnt_d  = cnt_q + 9'd1;
          line_d = line_q >> 32;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_en      = 1'b0;
    ram_we      = 4'h0;
    ram_addr    = '0;
    ram_wdata   = '0;
    inst_pvalid = 1'b0;
    inst_plast  = 1'b0;
    inst_prdata = '0;
    data_pvalid = 1'b0;
    data_prlast = 1'b0;
    data_prdata = '0;
    data_pwrdy  = 1'b0;
    if (!reset) begin
      if (issue) begin
        ram_en   = 1'b1;
        ram_addr = addr_q + RAM_AW'(cnt_q);
        if (state_q == DWR) begin
          ram_we    = strb_q;
          ram_wdata = line_q[31:0];
        end
      end
      if (vld_p1_q && (state_q == IRD)) begin
        inst_pvalid = 1'b1;
        inst_plast  = last_p1_q;
        inst_prdata = ram_rdata;
      end
      if (vld_p1_q && (state_q == DRD)) begin
        data_pvalid = 1'b1;
        data_prlast = last_p1_q;
        data_prdata = ram_rdata;
      end
      data_pwrdy = (state_q == DWR) && !issue;
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_mem_responder.sv
// Scoreboard bench for the memory responder: requesters push expected beats,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_ysyx_23060025_mem_responder;
  localparam int LINE_W = 128;
  localparam int RAM_AW = 16;
  localparam int MEMW   = 1 << RAM_AW;
  localparam int BEATS  = LINE_W / 32;

  logic clock = 1'b0, reset = 1'b1;
  logic inst_psel = 0; logic [31:0] inst_paddr = 0; logic [7:0] inst_plen = 0; logic [2:0] inst_psize = 0;
  logic inst_pvalid, inst_plast; logic [31:0] inst_prdata;
  logic data_prsel = 0; logic [31:0] data_praddr = 0; logic [7:0] data_prlen = 0; logic [2:0] data_prsize = 0;
  logic data_pvalid, data_prlast; logic [31:0] data_prdata;
  logic data_pwsel = 0; logic [31:0] data_pwaddr = 0; logic [LINE_W-1:0] data_pwdata = 0;
  logic [3:0] data_pwstrb = 0; logic [2:0] data_pwtype = 0;
  logic data_pwrdy, ram_en; logic [3:0] ram_we; logic [RAM_AW-1:0] ram_addr;
  logic [31:0] ram_wdata; logic [31:0] ram_rdata = 0;

  logic [31:0] ram [MEMW];
  logic [31:0] ref_mem [MEMW];
  logic ram_init = 1'b0;
  int cyc = 0, checks = 0, errors = 0;

  typedef struct {logic [31:0] data; logic last; int cyc;} beat_t;
  beat_t iq[$], dq[$];
  int wq[$];

  ysyx_23060025_mem_responder #(.LINE_W(LINE_W), .RAM_AW(RAM_AW)) dut (
    .clock(clock), .reset(reset),
    .inst_psel(inst_psel), .inst_paddr(inst_paddr), .inst_plen(inst_plen), .inst_psize(inst_psize),
    .inst_pvalid(inst_pvalid), .inst_plast(inst_plast), .inst_prdata(inst_prdata),
    .data_prsel(data_prsel), .data_praddr(data_praddr), .data_prlen(data_prlen), .data_prsize(data_prsize),
    .data_pvalid(data_pvalid), .data_prlast(data_prlast), .data_prdata(data_prdata),
    .data_pwsel(data_pwsel), .data_pwaddr(data_pwaddr), .data_pwdata(data_pwdata),
    .data_pwstrb(data_pwstrb), .data_pwtype(data_pwtype), .data_pwrdy(data_pwrdy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      'h100:   return 32'hA000_000A;
      'h101:   return 32'hB000_000B;
      'h102:   return 32'hC000_000C;
      'h103:   return 32'hD000_000D;
      'h10:    return 32'hAABB_CCDD;
      default: return (i * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endcase
  endfunction

  // Behavioural synchronous RAM: read data valid the cycle after ram_en.
  always @(posedge clock) begin
    if (!ram_init) begin
      for (int i = 0; i < MEMW; i++) ram[i] <= init_word(i);
      ram_init <= 1'b1;
    end else if (ram_en) begin
      if (ram_we == 4'h0) ram_rdata <= ram[ram_addr];
      else for (int b = 0; b < 4; b++) if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clock) begin
    beat_t b;
    if (reset) begin
      chk("reset_read_ports", 64'({inst_pvalid, inst_plast, data_pvalid, data_prlast, inst_prdata | data_prdata}), 64'(0));
      chk("reset_ram_ports", 64'({data_pwrdy, ram_en, ram_we, ram_addr, ram_wdata}), 64'(0));
    end else begin
      if (!ram_en) chk("we_without_en", 64'(ram_we), 64'(0));
      if (inst_pvalid) begin
        chk("data_port_quiet", 64'({data_pvalid, data_prlast, data_prdata}), 64'(0));
        if (iq.size() == 0) chk("inst_unexpected_beat", 64'(1), 64'(0));
        else begin
          b = iq.pop_front();
          chk("inst_data", 64'(inst_prdata), 64'(b.data));
          chk("inst_last", 64'(inst_plast), 64'(b.last));
          chk("inst_beat_cycle", 64'(cyc), 64'(b.cyc));
        end
      end else chk("inst_idle_quiet", 64'({inst_plast, inst_prdata}), 64'(0));
      if (data_pvalid) begin
        chk("inst_port_quiet", 64'({inst_pvalid, inst_plast, inst_prdata}), 64'(0));
        if (dq.size() == 0) chk("data_unexpected_beat", 64'(1), 64'(0));
        else begin
          b = dq.pop_front();
          chk("data_data", 64'(data_prdata), 64'(b.data));
          chk("data_last", 64'(data_prlast), 64'(b.last));
          chk("data_beat_cycle", 64'(cyc), 64'(b.cyc));
        end
      end else chk("data_idle_quiet", 64'({data_prlast, data_prdata}), 64'(0));
      if (data_pwrdy) begin
        if (wq.size() == 0) chk("unexpected_pwrdy", 64'(1), 64'(0));
        else chk("pwrdy_cycle", 64'(cyc), 64'(wq.pop_front()));
      end
    end
  end

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % MEMW);
  endfunction

  task automatic step();
    @(negedge clock); #1;
  endtask

  task automatic start_iread(input logic [31:0] a, input logic [7:0] len, input int tg);
    beat_t b;
    for (int k = 0; k <= int'(len); k++) begin
      b.data = ref_mem[(widx(a) + k) % MEMW]; b.last = (k == int'(len)); b.cyc = tg + 1 + k;
      iq.push_back(b);
    end
    inst_psel = 1; inst_paddr = a; inst_plen = len; inst_psize = 3'($urandom);
  endtask

  task automatic start_dread(input logic [31:0] a, input logic [7:0] len, input int tg);
    beat_t b;
    for (int k = 0; k <= int'(len); k++) begin
      b.data = ref_mem[(widx(a) + k) % MEMW]; b.last = (k == int'(len)); b.cyc = tg + 1 + k;
      dq.push_back(b);
    end
    data_prsel = 1; data_praddr = a; data_prlen = len; data_prsize = 3'($urandom);
  endtask

  task automatic start_write(input logic [31:0] a, input logic [LINE_W-1:0] d, input logic [3:0] strb,
                             input logic [2:0] typ, input int tg);
    int base;
    if (typ == 3'b001) begin
      base = (widx(a) / BEATS) * BEATS;
      for (int k = 0; k < BEATS; k++) ref_mem[base + k] = d[32*k +: 32];
      wq.push_back(tg + BEATS);
    end else begin
      for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
      wq.push_back(tg + 1);
    end
    data_pwsel = 1; data_pwaddr = a; data_pwdata = d; data_pwstrb = strb; data_pwtype = typ;
  endtask

  task automatic wait_iread(input int bound, input bit scramble);
    bit done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      step();
      if (inst_pvalid && inst_plast) done = 1;
      else if (scramble) begin inst_paddr = $urandom; inst_plen = 8'($urandom); end
    end
    inst_psel = 0;
    if (!done) chk("inst_read_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_dread(input int bound, input bit scramble);
    bit done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      step();
      if (data_pvalid && data_prlast) done = 1;
      else if (scramble) begin data_praddr = $urandom; data_prlen = 8'($urandom); end
    end
    data_prsel = 0;
    if (!done) chk("data_read_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_write(input int bound, input bit scramble);
    bit done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      step();
      if (data_pwrdy) done = 1;
      else if (scramble) begin
        data_pwaddr = $urandom; data_pwdata = {$urandom, $urandom, $urandom, $urandom};
        data_pwstrb = 4'($urandom); data_pwtype = 3'($urandom);
      end
    end
    data_pwsel = 0;
    if (!done) chk("write_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    int tw, td, ti, bad, kind, len;
    logic [31:0] r, a;
    int unsigned w;
    logic [2:0] typ;
    for (int i = 0; i < MEMW; i++) ref_mem[i] = init_word(i);
    idle(4);
    reset = 0;
    idle(2);

    // Instruction burst of four beats, then a request timed to the first IDLE edge
    start_iread(32'h400, 8'd3, cyc + 1);
    wait_iread(20, 0);
    idle(2);
    start_dread(32'h404, 8'd0, cyc + 1);
    wait_dread(20, 0);
    idle(3);

    // Line write
    start_write(32'h80, 128'h44444444_33333333_22222222_11111111, 4'h0, 3'b001, cyc + 1);
    wait_write(20, 0);
    idle(1);
    chk("line_word0", 64'(ram['h20]), 64'(32'h11111111));
    chk("line_word1", 64'(ram['h21]), 64'(32'h22222222));
    chk("line_word2", 64'(ram['h22]), 64'(32'h33333333));
    chk("line_word3", 64'(ram['h23]), 64'(32'h44444444));
    idle(2);

    // Strobed single-word write
    start_write(32'h40, {96'h0, 32'h11223344}, 4'b0101, 3'b000, cyc + 1);
    wait_write(20, 0);
    idle(1);
    chk("strobe_word", 64'(ram['h10]), 64'(32'hAA22CC44));
    idle(2);

    // Read wrapping past the top of the RAM
    start_dread({14'h0, 16'hFFFF, 2'b00}, 8'd1, cyc + 1);
    wait_dread(20, 0);
    idle(3);

    // All three requests at once: write, data read, instruction read
    tw = cyc + 1;
    td = tw + BEATS + 3;
    ti = td + 2 + 4;
    start_write(32'h200, {$urandom, $urandom, $urandom, $urandom}, 4'hF, 3'b001, tw);
    start_dread(32'h204, 8'd2, td);
    start_iread(32'h208, 8'd1, ti);
    fork
      wait_write(40, 0);
      wait_dread(40, 0);
      wait_iread(40, 0);
    join
    idle(3);

    // Reset during beat 1 of a four-beat instruction read
    start_iread(32'h400, 8'd3, cyc + 1);
    idle(3);
    reset = 1; inst_psel = 0; iq.delete();
    idle(2);
    reset = 0;
    idle(3);
    start_iread(32'h404, 8'd2, cyc + 1);
    wait_iread(20, 0);
    idle(3);

    // Randomised traffic
    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      w = ($urandom_range(0, 7) == 0) ? MEMW - 1 - $urandom_range(0, 5) : $urandom_range(0, 255);
      a = {r[31:18], w[15:0], r[1:0]};
      kind = $urandom_range(0, 3);
      len = $urandom_range(0, 7);
      case (kind)
        0: begin start_iread(a, 8'(len), cyc + 1); wait_iread(len + 20, 1); end
        1: begin start_dread(a, 8'(len), cyc + 1); wait_dread(len + 20, 1); end
        2: begin start_write(a, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom), 3'b001, cyc + 1);
                 wait_write(20, 1); end
        default: begin
          typ = 3'($urandom);
          if (typ == 3'b001) typ = 3'b000;
          start_write(a, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom), typ, cyc + 1);
          wait_write(20, 1);
        end
      endcase
      idle($urandom_range(3, 5));
    end

    idle(2);
    bad = 0;
    for (int i = 0; i < MEMW; i++) if (ram[i] !== ref_mem[i]) bad++;
    chk("mem_image_mismatches", 64'(bad), 64'(0));
    chk("inst_queue_drained", 64'(iq.size()), 64'(0));
    chk("data_queue_drained", 64'(dq.size()), 64'(0));
    chk("write_queue_drained", 64'(wq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
